// File: rtl/matrix_add_pkg.sv
// Shared definitions for the pairwise matrix adder sequencer: default sizes,
// controller state encoding and bus slice helpers.
package matrix_add_pkg;

   localparam int DW_DEF    = 16;
   localparam int NPAIR_DEF = 16;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Word 0 occupies the most significant slice of the operand bus.
   function automatic int opnd_msb(input int k, input int nword, input int dw);
      return (nword - k) * dw - 1;
   endfunction

   function automatic int sum_msb(input int p, input int npair, input int dw);
      return (npair - p) * dw - 1;
   endfunction

endpackage

// File: rtl/mia_opnd_bank.sv
// Operand register file: one indexed write port, all entries flattened onto
// the operand bus for the external adder.
module mia_opnd_bank
   import matrix_add_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int NWORD = 2 * NPAIR_DEF,
   parameter int CW    = $clog2(NWORD)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [CW-1:0]       widx,
   input  logic [DW-1:0]       wdata,
   output logic [NWORD*DW-1:0] opnd_bus
);

   logic [DW-1:0] mem [NWORD];

   // Entries only change on an accepted word, so the bus is stable between frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NWORD; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   for (genvar k = 0; k < NWORD; k++) begin : g_flat
      assign opnd_bus[opnd_msb(k, NWORD, DW) -: DW] = mem[k];
   end

endmodule

// File: rtl/matrix_add_seq_ctrl.sv
// Sequencer for the 16-lane pairwise adder: gathers a frame of operand words,
// captures the adder result one cycle later and offers it as one result beat.
module matrix_add_seq_ctrl
   import matrix_add_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int NPAIR = NPAIR_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DW-1:0]         s_data,
   input  logic                  s_last,
   output logic [2*NPAIR*DW-1:0] opnd_bus,
   input  logic [NPAIR*DW-1:0]   sum_bus,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [NPAIR*DW-1:0]   m_data,
   output logic                  busy,
   output logic                  err_len,
   output logic [15:0]           frame_cnt
);

   localparam int NWORD = 2 * NPAIR;
   localparam int CW    = $clog2(NWORD);
   localparam logic [CW-1:0] LAST_IDX = CW'(NWORD - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          accept;

   assign accept = s_valid && s_ready && (state == LOAD);
   assign busy   = (state != LOAD) || (cnt != '0);

   mia_opnd_bank #(
      .DW    (DW),
      .NWORD (NWORD),
      .CW    (CW)
   ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .we       (accept),
      .widx     (cnt),
      .wdata    (s_data),
      .opnd_bus (opnd_bus)
   );

   // An early s_last aborts the frame in place; a missing s_last on the final
   // word is only flagged, the frame still goes on to the adder.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         cnt       <= '0;
         s_ready   <= 1'b1;
         m_valid   <= 1'b0;
         m_data    <= '0;
         err_len   <= 1'b0;
         frame_cnt <= '0;
      end else begin
         err_len <= 1'b0;
         case (state)
            LOAD: begin
               if (accept) begin
                  if (cnt == LAST_IDX) begin
                     cnt     <= '0;
                     state   <= CALC;
                     s_ready <= 1'b0;
                     err_len <= !s_last;
                  end else if (s_last) begin
                     cnt     <= '0;
                     err_len <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            CALC: begin
               m_data  <= sum_bus;
               m_valid <= 1'b1;
               state   <= HOLD;
            end
            HOLD: begin
               if (m_ready) begin
                  m_valid   <= 1'b0;
                  frame_cnt <= frame_cnt + 16'd1;
                  s_ready   <= 1'b1;
                  state     <= LOAD;
               end
            end
            default: begin
               state   <= LOAD;
               cnt     <= '0;
               s_ready <= 1'b1;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_add_seq_ctrl.sv
// Directed bench for matrix_add_seq_ctrl; the bench also plays the external adder.
module tb_matrix_add_seq_ctrl;

   localparam int DW    = 16;
   localparam int NPAIR = 16;
   localparam int NWORD = 2 * NPAIR;
   localparam int BW    = NPAIR * DW;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  s_valid;
   logic                  s_ready;
   logic [DW-1:0]         s_data;
   logic                  s_last;
   logic [2*NPAIR*DW-1:0] opnd_bus;
   logic [BW-1:0]         sum_bus;
   logic                  m_valid;
   logic                  m_ready;
   logic [BW-1:0]         m_data;
   logic                  busy;
   logic                  err_len;
   logic [15:0]           frame_cnt;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;
   logic [DW-1:0] words [NWORD];

   matrix_add_seq_ctrl #(.DW(DW), .NPAIR(NPAIR)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .opnd_bus  (opnd_bus),
      .sum_bus   (sum_bus),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .busy      (busy),
      .err_len   (err_len),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // External combinational adder: lane p = word 2p + word 2p+1, modulo 2^DW.
   always_comb begin
      sum_bus = '0;
      for (int p = 0; p < NPAIR; p++) begin
         sum_bus[(NPAIR-p)*DW-1 -: DW] = opnd_bus[(NWORD-2*p)*DW-1 -: DW]
                                       + opnd_bus[(NWORD-2*p-1)*DW-1 -: DW];
      end
   end

   task automatic checkOutput(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] expSums();
      logic [BW-1:0] r;
      r = '0;
      for (int p = 0; p < NPAIR; p++) begin
         r[(NPAIR-p)*DW-1 -: DW] = words[2*p] + words[2*p+1];
      end
      return r;
   endfunction

   // Sends words[0..nwords-1]; returns #1 after the edge that accepted the last one.
   task automatic applyStimulus(input int nwords, input int last_at, input bit gaps);
      int g;
      int guard;
      for (int i = 0; i < nwords; i++) begin
         if (gaps) begin
            g = $urandom_range(0, 3);
            s_valid = 1'b0;
            repeat (g) begin
               @(posedge clk); #1;
            end
         end
         s_valid = 1'b1;
         s_data  = words[i];
         s_last  = (i == last_at);
         guard = 0;
         while (!s_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
         end
         if (!s_ready) checkOutput("s_ready_timeout", BW'(s_ready), BW'(1));
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Called in the cycle after the last accept; m_valid must rise one edge later.
   task automatic expectResult(input string tag);
      @(posedge clk); #1;
      checkOutput({tag, "_mvalid"}, BW'(m_valid), BW'(1));
      checkOutput({tag, "_mdata"}, m_data, expSums());
      if (m_ready) begin
         @(posedge clk); #1;
         exp_cnt = (exp_cnt + 1) % 65536;
         checkOutput({tag, "_mvalid_drop"}, BW'(m_valid), BW'(0));
         checkOutput({tag, "_frame_cnt"}, BW'(frame_cnt), BW'(exp_cnt));
         checkOutput({tag, "_sready"}, BW'(s_ready), BW'(1));
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_sready"}, BW'(s_ready), BW'(1));
      checkOutput({tag, "_mvalid"}, BW'(m_valid), BW'(0));
      checkOutput({tag, "_mdata"}, m_data, '0);
      checkOutput({tag, "_opnd"}, opnd_bus[BW-1:0], '0);
      checkOutput({tag, "_opnd_hi"}, opnd_bus[2*BW-1:BW], '0);
      checkOutput({tag, "_busy"}, BW'(busy), BW'(0));
      checkOutput({tag, "_errlen"}, BW'(err_len), BW'(0));
      checkOutput({tag, "_frame_cnt"}, BW'(frame_cnt), BW'(0));
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkReset("reset");
      rst = 1'b0;

      // Basic frame 1..32
      for (int i = 0; i < NWORD; i++) words[i] = DW'(i + 1);
      applyStimulus(NWORD, NWORD - 1, 1'b0);
      checkOutput("basic_errlen", BW'(err_len), BW'(0));
      checkOutput("basic_mvalid_early", BW'(m_valid), BW'(0));
      checkOutput("basic_busy", BW'(busy), BW'(1));
      checkOutput("basic_sready", BW'(s_ready), BW'(0));
      @(posedge clk); #1;
      checkOutput("basic_mvalid", BW'(m_valid), BW'(1));
      checkOutput("basic_lane0", BW'(m_data[BW-1 -: DW]), BW'(16'h0003));
      checkOutput("basic_lane15", BW'(m_data[DW-1:0]), BW'(16'h003F));
      checkOutput("basic_mdata", m_data, expSums());
      @(posedge clk); #1;
      exp_cnt = 1;
      checkOutput("basic_frame_cnt", BW'(frame_cnt), BW'(1));
      checkOutput("basic_mvalid_drop", BW'(m_valid), BW'(0));
      checkOutput("basic_busy_idle", BW'(busy), BW'(0));

      // Modulo wrap: 0xFFFF pairs and a 0x8000 pair on lane 3
      for (int i = 0; i < NWORD; i++) words[i] = 16'hFFFF;
      words[6] = 16'h8000;
      words[7] = 16'h8000;
      applyStimulus(NWORD, NWORD - 1, 1'b0);
      m_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("wrap_lane0", BW'(m_data[BW-1 -: DW]), BW'(16'hFFFE));
      checkOutput("wrap_lane3", BW'(m_data[(NPAIR-3)*DW-1 -: DW]), BW'(16'h0000));
      checkOutput("wrap_mdata", m_data, expSums());

      // Backpressure on the held wrap result
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checkOutput("bp_mvalid", BW'(m_valid), BW'(1));
         checkOutput("bp_mdata", m_data, expSums());
         checkOutput("bp_sready", BW'(s_ready), BW'(0));
      end
      checkOutput("bp_frame_cnt_held", BW'(frame_cnt), BW'(exp_cnt));
      m_ready = 1'b1;
      @(posedge clk); #1;
      exp_cnt++;
      checkOutput("bp_release_mvalid", BW'(m_valid), BW'(0));
      checkOutput("bp_release_sready", BW'(s_ready), BW'(1));
      checkOutput("bp_release_cnt", BW'(frame_cnt), BW'(exp_cnt));

      // Early last on word 5 aborts the frame
      for (int i = 0; i < NWORD; i++) words[i] = DW'(16'h0100 + i);
      applyStimulus(5, 4, 1'b0);
      checkOutput("early_errlen", BW'(err_len), BW'(1));
      checkOutput("early_busy", BW'(busy), BW'(0));
      checkOutput("early_opnd_w0", BW'(opnd_bus[2*BW-1 -: DW]), BW'(16'h0100));
      @(posedge clk); #1;
      checkOutput("early_errlen_pulse", BW'(err_len), BW'(0));
      checkOutput("early_no_mvalid", BW'(m_valid), BW'(0));
      checkOutput("early_frame_cnt", BW'(frame_cnt), BW'(exp_cnt));
      for (int i = 0; i < NWORD; i++) words[i] = DW'(3 * i + 7);
      applyStimulus(NWORD, NWORD - 1, 1'b0);
      checkOutput("after_early_errlen", BW'(err_len), BW'(0));
      expectResult("after_early");

      // Missing s_last on the final word still completes the frame
      for (int i = 0; i < NWORD; i++) words[i] = DW'(16'h1111 * (i % 4));
      applyStimulus(NWORD, -1, 1'b0);
      checkOutput("nolast_errlen", BW'(err_len), BW'(1));
      expectResult("nolast");

      // Reset after 20 words
      for (int i = 0; i < NWORD; i++) words[i] = DW'(16'hA000 + i);
      applyStimulus(20, -1, 1'b0);
      checkOutput("midreset_busy_before", BW'(busy), BW'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      checkReset("midreset");
      rst = 1'b0;
      exp_cnt = 0;
      for (int i = 0; i < NWORD; i++) words[i] = DW'(16'h0F00 - 5 * i);
      applyStimulus(NWORD, NWORD - 1, 1'b0);
      expectResult("fresh");

      // Throttled random frames
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < NWORD; i++) words[i] = DW'($urandom);
         applyStimulus(NWORD, NWORD - 1, 1'b1);
         expectResult("throttle");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
